rect_flip_engine: RTL and testbench

RECT_FLIP_ENGINE -- requirements
Module: rect_flip_engine

---
 rtl/rect_flip_pkg.sv | 31 +++
 rtl/rect_flip_engine_if.sv | 32 +++
 rtl/rect_mask_gen.sv | 58 +++++
 rtl/rect_flip_engine.sv | 137 +++++++++++++
 tb/tb_rect_flip_engine.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_flip_pkg.sv
// Purpose : shared types for the rectangle flip engine (modes, result status, FSM states).
// Latency : n/a (types and a pure helper function only).
// Backpr. : n/a.
package rect_flip_pkg;

  typedef enum logic [1:0] {
    MODE_FORCE = 2'd0,
    MODE_COND  = 2'd1,
    MODE_PROBE = 2'd2,
    MODE_RSVD  = 2'd3   // behaves as PROBE
  } mode_e;

  typedef enum logic [1:0] {
    ST_FLIPPED      = 2'd0,
    ST_NOT_CHECKER  = 2'd1,
    ST_DEGENERATE   = 2'd2,
    ST_OUT_OF_RANGE = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Matrix storage is column-major with element (0,0) in the MSB.
  function automatic int elem_pos(input int r, input int c, input int rows, input int n);
    return n - 1 - (c * rows + r);
  endfunction

endpackage

// File: rtl/rect_flip_engine_if.sv
// Purpose : command/result handshake bundle between a requester and rect_flip_engine.
// Latency : n/a (wires only).
// Backpr. : cmd_ready / res_ready valid-ready pairs.
// Ports   : master = requester (drives cmd_*, res_ready); slave = engine (drives cmd_ready, res_*).
interface rect_flip_engine_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_r1;
  logic [RW-1:0] cmd_r2;
  logic [CW-1:0] cmd_c1;
  logic [CW-1:0] cmd_c2;
  logic [1:0]    cmd_mode;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_status;

  modport master (
    output cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, cmd_mode, res_ready,
    input  cmd_ready, res_valid, res_status
  );

  modport slave (
    input  cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, cmd_mode, res_ready,
    output cmd_ready, res_valid, res_status
  );
endinterface

// File: rtl/rect_mask_gen.sv
// Purpose : rectangle corner indices -> four-hot flip mask, corner bit values, range/degenerate flags.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_matrix, i_r1/i_r2/i_c1/i_c2 in; o_mask, o_b11/o_b12/o_b21/o_b22, o_oor, o_degen out.
module rect_mask_gen
  import rect_flip_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic [ROWS*COLS-1:0] i_matrix,
  input  logic [RW-1:0]        i_r1,
  input  logic [RW-1:0]        i_r2,
  input  logic [CW-1:0]        i_c1,
  input  logic [CW-1:0]        i_c2,
  output logic [ROWS*COLS-1:0] o_mask,
  output logic                 o_b11,   // M(r1,c1)
  output logic                 o_b12,   // M(r1,c2)
  output logic                 o_b21,   // M(r2,c1)
  output logic                 o_b22,   // M(r2,c2)
  output logic                 o_oor,
  output logic                 o_degen
);
  localparam int N = ROWS * COLS;

  int w_p11, w_p12, w_p21, w_p22;

  assign w_p11 = elem_pos(int'(i_r1), int'(i_c1), ROWS, N);
  assign w_p12 = elem_pos(int'(i_r1), int'(i_c2), ROWS, N);
  assign w_p21 = elem_pos(int'(i_r2), int'(i_c1), ROWS, N);
  assign w_p22 = elem_pos(int'(i_r2), int'(i_c2), ROWS, N);

  assign o_oor   = (int'(i_r1) >= ROWS) || (int'(i_r2) >= ROWS) ||
                   (int'(i_c1) >= COLS) || (int'(i_c2) >= COLS);
  assign o_degen = (i_r1 == i_r2) || (i_c1 == i_c2);

  // Positions are matched by a scan rather than a direct variable bit-select so an
  // out-of-range index never addresses a bit that does not exist.
  always_comb begin
    o_mask = '0;
    o_b11  = 1'b0;
    o_b12  = 1'b0;
    o_b21  = 1'b0;
    o_b22  = 1'b0;
    if (!o_oor) begin
      for (int i = 0; i < N; i++) begin
        if (i == w_p11 || i == w_p12 || i == w_p21 || i == w_p22) o_mask[i] = 1'b1;
        if (i == w_p11) o_b11 = i_matrix[i];
        if (i == w_p12) o_b12 = i_matrix[i];
        if (i == w_p21) o_b21 = i_matrix[i];
        if (i == w_p22) o_b22 = i_matrix[i];
      end
    end
  end

endmodule

// File: rtl/rect_flip_engine.sv
// Purpose : holds a ROWSxCOLS bit matrix and applies/evaluates rectangle corner flips on command.
// Latency : command accepted at edge t, result valid from edge t+2; one command in flight.
// Backpr. : cmd_ready low unless idle with no load; result held until res_ready.
// Ports   : clk, rst (sync, active-high), load_en/load_data, bus (slave), m_out, flip_count, reject_count.
module rect_flip_engine
  import rect_flip_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [ROWS*COLS-1:0] load_data,
  rect_flip_engine_if.slave    bus,
  output logic [ROWS*COLS-1:0] m_out,
  output logic [CNT_W-1:0]     flip_count,
  output logic [CNT_W-1:0]     reject_count
);
  localparam int N  = ROWS * COLS;
  localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1;

  state_e          r_state, w_state_nxt;
  logic [RW-1:0]   r_r1, r_r2;
  logic [CW-1:0]   r_c1, r_c2;
  mode_e           r_mode;
  logic [N-1:0]    r_matrix;
  status_e         r_status;
  logic [CNT_W-1:0] r_flip_cnt, r_rej_cnt;

  logic [N-1:0]    w_mask;
  logic            w_b11, w_b12, w_b21, w_b22;
  logic            w_oor, w_degen, w_checker;
  logic            w_cmd_hs, w_res_hs;
  status_e         w_eval_status;
  logic            w_do_flip, w_is_reject;

  assign bus.cmd_ready  = (r_state == S_IDLE) && !load_en;
  assign bus.res_valid  = (r_state == S_RESP);
  assign bus.res_status = r_status;
  assign m_out          = r_matrix;
  assign flip_count     = r_flip_cnt;
  assign reject_count   = r_rej_cnt;

  assign w_cmd_hs = bus.cmd_valid && bus.cmd_ready;
  assign w_res_hs = bus.res_valid && bus.res_ready;

  // Works on the captured command so input changes after acceptance are ignored.
  rect_mask_gen #(
    .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)
  ) u_mask (
    .i_matrix (r_matrix),
    .i_r1     (r_r1),
    .i_r2     (r_r2),
    .i_c1     (r_c1),
    .i_c2     (r_c2),
    .o_mask   (w_mask),
    .o_b11    (w_b11),
    .o_b12    (w_b12),
    .o_b21    (w_b21),
    .o_b22    (w_b22),
    .o_oor    (w_oor),
    .o_degen  (w_degen)
  );

  assign w_checker = (w_b11 == w_b22) && (w_b12 == w_b21) && (w_b11 != w_b12);

  always_comb begin
    w_eval_status = ST_FLIPPED;
    w_do_flip     = 1'b0;
    if (w_oor) begin
      w_eval_status = ST_OUT_OF_RANGE;
    end else if (w_degen) begin
      w_eval_status = ST_DEGENERATE;
    end else begin
      case (r_mode)
        MODE_FORCE: w_do_flip = 1'b1;
        MODE_COND: begin
          if (w_checker) w_do_flip = 1'b1;
          else           w_eval_status = ST_NOT_CHECKER;
        end
        // PROBE and the reserved code only report what COND would do.
        default: if (!w_checker) w_eval_status = ST_NOT_CHECKER;
      endcase
    end
    w_is_reject = ((r_mode == MODE_FORCE) || (r_mode == MODE_COND)) &&
                  (w_eval_status != ST_FLIPPED);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_hs) w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = S_RESP;
      S_RESP:  if (w_res_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_matrix   <= '0;
      r_status   <= ST_FLIPPED;
      r_flip_cnt <= '0;
      r_rej_cnt  <= '0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_mode     <= MODE_FORCE;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && load_en) r_matrix <= load_data;
      if (w_cmd_hs) begin
        r_r1   <= bus.cmd_r1;
        r_r2   <= bus.cmd_r2;
        r_c1   <= bus.cmd_c1;
        r_c2   <= bus.cmd_c2;
        r_mode <= mode_e'(bus.cmd_mode);
      end
      // Result, matrix and counters all commit on the EVAL->RESP edge so they
      // are coherent in the first cycle res_valid is high.
      if (r_state == S_EVAL) begin
        r_status <= w_eval_status;
        if (w_do_flip) begin
          r_matrix <= r_matrix ^ w_mask;
          if (r_flip_cnt != {CNT_W{1'b1}}) r_flip_cnt <= r_flip_cnt + CNT_W'(1);
        end
        if (w_is_reject && (r_rej_cnt != {CNT_W{1'b1}})) r_rej_cnt <= r_rej_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rect_flip_engine.sv
module tb_rect_flip_engine;
  import rect_flip_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4x4 instance
  logic        load0_en;
  logic [15:0] load0_dat;
  logic [15:0] m0, fc0, rc0;
  rect_flip_engine_if #(.ROWS(4), .COLS(4)) bus0 ();
  rect_flip_engine #(.ROWS(4), .COLS(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .load_en(load0_en), .load_data(load0_dat), .bus(bus0),
    .m_out(m0), .flip_count(fc0), .reject_count(rc0)
  );

  // 3x5 instance with narrow counters to reach saturation quickly
  logic        load1_en;
  logic [14:0] load1_dat;
  logic [14:0] m1;
  logic [1:0]  fc1, rc1;
  rect_flip_engine_if #(.ROWS(3), .COLS(5)) bus1 ();
  rect_flip_engine #(.ROWS(3), .COLS(5), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .load_en(load1_en), .load_data(load1_dat), .bus(bus1),
    .m_out(m1), .flip_count(fc1), .reject_count(rc1)
  );

  typedef struct {
    logic [1:0]  st;
    logic [15:0] m;
    logic [15:0] f;
    logic [15:0] rj;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mdl_m, mdl_f, mdl_rj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the 4x4 instance: element (r,c) lives at bit 15-(c*4+r).
  task automatic model_cmd(input int r1, input int r2, input int c1, input int c2,
                           input logic [1:0] mode);
    exp_t e;
    logic [1:0] st;
    logic b11, b12, b21, b22, cb, flip;
    flip = 1'b0;
    if (r1 > 3 || r2 > 3 || c1 > 3 || c2 > 3) st = 2'd3;
    else if (r1 == r2 || c1 == c2)             st = 2'd2;
    else begin
      b11 = mdl_m[15-(c1*4+r1)];
      b12 = mdl_m[15-(c2*4+r1)];
      b21 = mdl_m[15-(c1*4+r2)];
      b22 = mdl_m[15-(c2*4+r2)];
      cb  = (b11 == b22) && (b12 == b21) && (b11 != b12);
      case (mode)
        2'd0: begin st = 2'd0; flip = 1'b1; end
        2'd1: begin st = cb ? 2'd0 : 2'd1; flip = cb; end
        default: st = cb ? 2'd0 : 2'd1;
      endcase
    end
    if (flip) begin
      mdl_m[15-(c1*4+r1)] = ~mdl_m[15-(c1*4+r1)];
      mdl_m[15-(c2*4+r1)] = ~mdl_m[15-(c2*4+r1)];
      mdl_m[15-(c1*4+r2)] = ~mdl_m[15-(c1*4+r2)];
      mdl_m[15-(c2*4+r2)] = ~mdl_m[15-(c2*4+r2)];
      if (mdl_f != 16'hFFFF) mdl_f = mdl_f + 16'd1;
    end
    if ((mode == 2'd0 || mode == 2'd1) && st != 2'd0 && mdl_rj != 16'hFFFF)
      mdl_rj = mdl_rj + 16'd1;
    e.st = st; e.m = mdl_m; e.f = mdl_f; e.rj = mdl_rj;
    sb0.push_back(e);
  endtask

  // Entered and left on a falling edge.
  task automatic load0(input logic [15:0] d);
    load0_en  = 1'b1;
    load0_dat = d;
    @(negedge clk);
    load0_en  = 1'b0;
    mdl_m     = d;
    chk("load_m_out", m0, d);
  endtask

  task automatic do_cmd(input int r1, input int r2, input int c1, input int c2,
                        input logic [1:0] mode, input int hold,
                        input bit with_load, input logic [15:0] ld);
    int n;
    exp_t e;
    logic [1:0] st0;
    bus0.res_ready = (hold == 0);
    bus0.cmd_r1 = 2'(r1); bus0.cmd_r2 = 2'(r2);
    bus0.cmd_c1 = 2'(c1); bus0.cmd_c2 = 2'(c2);
    bus0.cmd_mode = mode;
    bus0.cmd_valid = 1'b1;
    if (with_load) begin
      load0_en  = 1'b1;
      load0_dat = ld;
      #1;
      chk("ld_cmd_ready_low", bus0.cmd_ready, 1'b0);
      @(negedge clk);
      load0_en = 1'b0;
      mdl_m    = ld;
      #1;
      chk("ld_taken", m0, ld);
    end
    #1;
    n = 0;
    while (!bus0.cmd_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("cmd_ready_wait", n < 20, 1'b1);
    model_cmd(r1, r2, c1, c2, mode);
    @(posedge clk);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    // Scramble fields after acceptance; the accepted command must not change.
    bus0.cmd_r1 = 2'($urandom); bus0.cmd_r2 = 2'($urandom);
    bus0.cmd_c1 = 2'($urandom); bus0.cmd_c2 = 2'($urandom);
    bus0.cmd_mode = 2'($urandom);
    n = 1;
    while (!bus0.res_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("latency", n, 2);
    e = sb0.pop_front();
    if (hold > 0) begin
      st0 = bus0.res_status;
      load0_en  = 1'b1;
      load0_dat = ~e.m;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", bus0.res_valid, 1'b1);
        chk("hold_status", bus0.res_status, st0);
        chk("hold_cmd_ready", bus0.cmd_ready, 1'b0);
        chk("hold_load_ignored", m0, e.m);
      end
      load0_en = 1'b0;
      bus0.res_ready = 1'b1;
    end
    chk("status", bus0.res_status, e.st);
    chk("m_out", m0, e.m);
    chk("flip_count", fc0, e.f);
    chk("reject_count", rc0, e.rj);
    @(posedge clk);
    @(negedge clk);
    chk("res_valid_drop", bus0.res_valid, 1'b0);
  endtask

  task automatic cmd1(input int r1, input int r2, input int c1, input int c2,
                      input logic [1:0] mode, input logic [1:0] est,
                      input logic [14:0] em, input logic [1:0] ef, input logic [1:0] erj);
    int n;
    exp_t e;
    e.st = est; e.m = {1'b0, em}; e.f = {14'd0, ef}; e.rj = {14'd0, erj};
    sb1.push_back(e);
    bus1.res_ready = 1'b1;
    bus1.cmd_r1 = 2'(r1); bus1.cmd_r2 = 2'(r2);
    bus1.cmd_c1 = 3'(c1); bus1.cmd_c2 = 3'(c2);
    bus1.cmd_mode  = mode;
    bus1.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    n = 1;
    while (!bus1.res_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("d1_latency", n, 2);
    e = sb1.pop_front();
    chk("d1_status", bus1.res_status, e.st);
    chk("d1_m_out", m1, e.m[14:0]);
    chk("d1_flip_count", fc1, e.f[1:0]);
    chk("d1_reject_count", rc1, e.rj[1:0]);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic pre_valid, any_valid;
    rst = 1'b1;
    load0_en = 1'b0; load0_dat = '0;
    load1_en = 1'b0; load1_dat = '0;
    bus0.cmd_valid = 1'b0; bus0.res_ready = 1'b1; bus0.cmd_mode = '0;
    bus0.cmd_r1 = '0; bus0.cmd_r2 = '0; bus0.cmd_c1 = '0; bus0.cmd_c2 = '0;
    bus1.cmd_valid = 1'b0; bus1.res_ready = 1'b1; bus1.cmd_mode = '0;
    bus1.cmd_r1 = '0; bus1.cmd_r2 = '0; bus1.cmd_c1 = '0; bus1.cmd_c2 = '0;
    mdl_m = '0; mdl_f = '0; mdl_rj = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_out", m0, 16'h0000);
    chk("rst_res_valid", bus0.res_valid, 1'b0);
    chk("rst_cmd_ready", bus0.cmd_ready, 1'b1);
    chk("rst_status", bus0.res_status, 2'd0);
    chk("rst_flip", fc0, 16'd0);
    chk("rst_reject", rc0, 16'd0);

    // Directed corner cases on the 4x4 instance
    load0(16'h0000);
    do_cmd(0, 1, 0, 1, 2'd0, 0, 0, '0);        // FORCE -> CC00
    load0(16'h8400);
    do_cmd(0, 1, 0, 1, 2'd1, 0, 0, '0);        // COND  -> 4800
    do_cmd(0, 1, 0, 1, 2'd1, 0, 0, '0);        // COND  -> 8400
    load0(16'h0000);
    do_cmd(0, 1, 0, 1, 2'd1, 0, 0, '0);        // NOT_CHECKER
    load0(16'h8400);
    do_cmd(0, 1, 0, 1, 2'd2, 0, 0, '0);        // PROBE, would flip
    do_cmd(0, 1, 0, 1, 2'd3, 0, 0, '0);        // reserved acts as PROBE
    do_cmd(0, 2, 1, 3, 2'd2, 0, 0, '0);        // PROBE, not checkerboard
    do_cmd(2, 2, 0, 3, 2'd0, 0, 0, '0);        // DEGENERATE rows
    do_cmd(1, 3, 2, 2, 2'd1, 0, 0, '0);        // DEGENERATE cols
    do_cmd(3, 0, 3, 0, 2'd0, 3, 0, '0);        // back-pressure, extreme corners
    do_cmd(0, 1, 0, 1, 2'd1, 0, 1, 16'h8400);  // load and command together

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) load0(16'($urandom));
      do_cmd($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 1), 0, '0);
    end

    // Reset while a result is pending, with load and command also asserted
    bus0.cmd_r1 = 2'd0; bus0.cmd_r2 = 2'd1; bus0.cmd_c1 = 2'd0; bus0.cmd_c2 = 2'd1;
    bus0.cmd_mode = 2'd0; bus0.res_ready = 1'b0; bus0.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    n = 1;
    while (!bus0.res_valid && n < 20) begin
      @(negedge clk); n++;
    end
    pre_valid = bus0.res_valid;
    chk("rst_pre_valid", pre_valid, 1'b1);
    rst = 1'b1;
    load0_en = 1'b1; load0_dat = 16'hFFFF; bus0.cmd_valid = 1'b1;
    @(negedge clk);
    chk("rstr_res_valid", bus0.res_valid, 1'b0);
    chk("rstr_m_out", m0, 16'h0000);
    chk("rstr_flip", fc0, 16'd0);
    chk("rstr_reject", rc0, 16'd0);
    chk("rstr_status", bus0.res_status, 2'd0);
    rst = 1'b0;
    load0_en = 1'b0; bus0.cmd_valid = 1'b0; bus0.res_ready = 1'b1;
    mdl_m = '0; mdl_f = '0; mdl_rj = '0;
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_valid = any_valid | bus0.res_valid;
    end
    chk("rstr_no_result", any_valid, 1'b0);
    do_cmd(0, 1, 0, 1, 2'd0, 0, 0, '0);        // engine usable after reset

    // 3x5 instance: range checks, max-index corners, 2-bit counter saturation
    cmd1(3, 0, 0, 1, 2'd0, 2'd3, 15'h0000, 2'd0, 2'd1);
    cmd1(0, 1, 0, 5, 2'd0, 2'd3, 15'h0000, 2'd0, 2'd2);
    cmd1(2, 0, 4, 0, 2'd0, 2'd0, 15'h5005, 2'd1, 2'd2);
    cmd1(0, 1, 0, 1, 2'd0, 2'd0, 15'h3C05, 2'd2, 2'd2);
    cmd1(0, 1, 0, 1, 2'd0, 2'd0, 15'h5005, 2'd3, 2'd2);
    cmd1(2, 0, 4, 0, 2'd0, 2'd0, 15'h0000, 2'd3, 2'd2);
    cmd1(0, 1, 0, 1, 2'd1, 2'd1, 15'h0000, 2'd3, 2'd3);
    cmd1(1, 1, 0, 2, 2'd0, 2'd2, 15'h0000, 2'd3, 2'd3);
    cmd1(2, 0, 3, 1, 2'd2, 2'd1, 15'h0000, 2'd3, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
